neuron_layer_sched: RTL and testbench
=====================================

NEURON_LAYER_SCHED -- requirements
Module: neuron_layer_sched

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of weight sets time-multiplexed onto one neuron datapath (power of two, 2..16).
REQ-002 SHALL have parameter LATENCY, default 3, clock edges from neuron input sampling to valid neuron y.
REQ-003 SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cfg_we  input  1  weight-set write strobe.
REQ-007 cfg_addr  input  log2(N_NEURONS)  weight-set index.
REQ-008 cfg_w1, cfg_w2, cfg_b  input  8 each  signed weight/bias values.
REQ-009 cfg_err  output  1  one-cycle pulse: write dropped because block busy.
REQ-010 in_valid  input  1  input vector valid.
REQ-011 in_ready  output  1  block can accept a vector.
REQ-012 in_x1, in_x2  input  8 each  signed input vector.
REQ-013 n_x1, n_x2, n_w1, n_w2, n_b  output  8 each  signed drive to neuron datapath.
REQ-014 n_y  input  16  signed neuron result (post-ReLU).
REQ-015 out_valid  input-side ready out_ready  output/input  1 each  result stream handshake.
REQ-016 out_idx  output  log2(N_NEURONS)  neuron index of out_y.
REQ-017 out_y  output  16  signed result; out_last  output  1  marks final result.
REQ-018 out_max_idx  output  log2(N_NEURONS)  index of largest result in current layer pass.

Function
REQ-019 States: IDLE, ISSUE, DRAIN, OUTPUT.
REQ-020 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge; latch in_x1/in_x2, go ISSUE, issue counter k=0.
REQ-021 ISSUE cycle k (0..N_NEURONS-1): n_x* = latched inputs, n_w1/n_w2/n_b = weight set k; after k=N_NEURONS-1 go DRAIN.
REQ-022 Outside ISSUE, n_x1, n_x2, n_w1, n_w2, n_b SHALL be driven 0.
REQ-023 A LATENCY-deep valid/index tag delay line SHALL track issues; n_y captured into result buffer entry k at end of cycle k+LATENCY (cycle 0 = first ISSUE cycle); untagged n_y ignored.
REQ-024 DRAIN SHALL last exactly LATENCY cycles, then OUTPUT; with defaults out_valid first high in cycle 7.
REQ-025 out_max_idx SHALL be updated at each capture: strictly greater replaces; ties keep lower index; all results 0 gives index 0; stable throughout OUTPUT.
REQ-026 OUTPUT: out_valid=1, out_idx/out_y = buffer entry j, j from 0; advance only on out_valid & out_ready; out_y/out_idx held stable while out_ready=0.
REQ-027 out_last=1 when j=N_NEURONS-1; its handshake returns to IDLE, in_ready=1 next cycle.
REQ-028 cfg_we in IDLE SHALL write weight set cfg_addr at the edge; cfg_we in any other state SHALL be dropped and cfg_err pulse 1 next cycle.
REQ-029 cfg_we and accept on same edge in IDLE: write takes effect, and the new set is used by that pass.
REQ-030 in_valid outside IDLE SHALL be ignored (no latch, no state change).

Reset
REQ-031 rst SHALL force IDLE, all weight sets, buffer, tags, counters and out_max_idx to 0; in_ready=1, out_valid=0, out_last=0, cfg_err=0, out_y=0, n_* = 0.
REQ-032 rst during any state SHALL abort the pass; no output of the aborted pass SHALL appear after rst deasserts.

Verification
REQ-033 Load sets 0..3 with (w1,w2,b)=(1,1,0),(2,0,1),(-1,-1,0),(0,3,-2), accept x=(10,20) with behavioural 3-cycle neuron, out_ready=1 -> out_y 30,21,0,58 idx 0..3, out_last on idx 3, out_max_idx=3, out_valid first in cycle 7.
REQ-034 Same pass, out_ready low 5 cycles at j=1 -> out_y=21 held, no loss, order preserved.
REQ-035 cfg_we during ISSUE -> cfg_err single pulse, weight set unchanged in next pass.
REQ-036 Results (5,5,2,0) -> out_max_idx=0 (tie keeps lower index).
REQ-037 rst asserted in DRAIN -> immediate IDLE, in_ready=1, out_valid never asserted, weights read back 0.
REQ-038 in_valid held high throughout -> exactly one accept per pass, next accept on edge after out_last handshake.

Source files
------------

// File: rtl/neuron_layer_sched.sv
// neuron_layer_sched: time-multiplexes N_NEURONS weight sets onto one
// external neuron datapath, collects the results and streams them out.
// Ports: clk, rst (async, active-high); cfg_we/cfg_addr/cfg_w1/cfg_w2/cfg_b
// weight-set writes with cfg_err on a dropped write; in_valid/in_ready/
// in_x1/in_x2 input vector; n_x1/n_x2/n_w1/n_w2/n_b drive and n_y result of
// the neuron; out_valid/out_ready/out_idx/out_y/out_last result stream and
// out_max_idx argmax of the current pass.
module neuron_layer_sched #(
  parameter int N_NEURONS = 4,
  parameter int LATENCY = 3,
  localparam int AW = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [7:0]    cfg_w1,
  input  logic signed [7:0]    cfg_w2,
  input  logic signed [7:0]    cfg_b,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [7:0]    in_x1,
  input  logic signed [7:0]    in_x2,
  output logic signed [7:0]    n_x1,
  output logic signed [7:0]    n_x2,
  output logic signed [7:0]    n_w1,
  output logic signed [7:0]    n_w2,
  output logic signed [7:0]    n_b,
  input  logic signed [15:0]   n_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW-1:0]        out_idx,
  output logic signed [15:0]   out_y,
  output logic                 out_last,
  output logic [AW-1:0]        out_max_idx
);

  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);
  localparam logic [DW-1:0] DLAST = DW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT
  } state_t;

  state_t state;
  logic [AW-1:0] k;
  logic [AW-1:0] j;
  logic [DW-1:0] dcnt;
  logic signed [7:0] x1_q;
  logic signed [7:0] x2_q;
  logic signed [7:0] w1_q [N_NEURONS];
  logic signed [7:0] w2_q [N_NEURONS];
  logic signed [7:0] b_q [N_NEURONS];
  logic signed [15:0] res_q [N_NEURONS];
  logic tag_v [LATENCY];
  logic [AW-1:0] tag_i [LATENCY];
  logic signed [15:0] max_y;
  logic [AW-1:0] max_idx;
  logic issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      j <= '0;
      dcnt <= '0;
      x1_q <= '0;
      x2_q <= '0;
      max_y <= '0;
      max_idx <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
        b_q[i] <= '0;
        res_q[i] <= '0;
      end
      for (int i = 0; i < LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_i[i] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      if (cfg_we && state == IDLE) begin
        w1_q[cfg_addr] <= cfg_w1;
        w2_q[cfg_addr] <= cfg_w2;
        b_q[cfg_addr] <= cfg_b;
      end
      // tag follows each issued operand set through the neuron pipeline
      tag_v[0] <= issue;
      tag_i[0] <= k;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
      if (tag_v[LATENCY-1]) begin
        res_q[tag_i[LATENCY-1]] <= n_y;
        // entry 0 always seeds the max; later ties keep the lower index
        if (tag_i[LATENCY-1] == '0 || n_y > max_y) begin
          max_y <= n_y;
          max_idx <= tag_i[LATENCY-1];
        end
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x1_q <= in_x1;
            x2_q <= in_x2;
            k <= '0;
            j <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (k == LAST) begin
            dcnt <= '0;
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == DLAST) state <= OUTPUT;
          else dcnt <= dcnt + 1'b1;
        end
        OUTPUT: begin
          if (out_ready) begin
            if (j == LAST) begin
              j <= '0;
              state <= IDLE;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue = (state == ISSUE);
  assign n_x1 = issue ? x1_q : '0;
  assign n_x2 = issue ? x2_q : '0;
  assign n_w1 = issue ? w1_q[k] : '0;
  assign n_w2 = issue ? w2_q[k] : '0;
  assign n_b = issue ? b_q[k] : '0;

  assign in_ready = (state == IDLE);
  assign out_valid = (state == OUTPUT);
  assign out_idx = out_valid ? j : '0;
  assign out_y = out_valid ? res_q[j] : '0;
  assign out_last = out_valid && (j == LAST);
  assign out_max_idx = max_idx;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// tb_neuron_layer_sched: randomized bench with a behavioural 3-cycle neuron
// and a reference model of layer results, argmax and stream order.
module tb_neuron_layer_sched;

  localparam int N = 4;
  localparam int L = 3;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic signed [7:0] cfg_w1, cfg_w2, cfg_b;
  logic cfg_err;
  logic in_valid, in_ready;
  logic signed [7:0] in_x1, in_x2;
  logic signed [7:0] n_x1, n_x2, n_w1, n_w2, n_b;
  logic signed [15:0] n_y;
  logic out_valid, out_ready, out_last;
  logic [AW-1:0] out_idx, out_max_idx;
  logic signed [15:0] out_y;

  int n_chk = 0;
  int n_pass = 0;

  int wm1 [N];
  int wm2 [N];
  int wmb [N];
  int exp_y [N];
  int exp_max;

  always #5 clk = ~clk;

  neuron_layer_sched #(.N_NEURONS(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_w1(cfg_w1), .cfg_w2(cfg_w2), .cfg_b(cfg_b),
    .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2),
    .n_x1(n_x1), .n_x2(n_x2),
    .n_w1(n_w1), .n_w2(n_w2), .n_b(n_b),
    .n_y(n_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_y(out_y),
    .out_last(out_last), .out_max_idx(out_max_idx)
  );

  function automatic logic signed [15:0] neuron_f(
    input int x1, input int x2, input int w1,
    input int w2, input int b);
    int s;
    s = w1 * x1 + w2 * x2 + b;
    if (s < 0) s = 0;
    if (s > 32767) s = 32767;
    return 16'(s);
  endfunction

  // behavioural neuron: samples drive at each edge, result L edges later
  logic signed [15:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= neuron_f(n_x1, n_x2, n_w1, n_w2, n_b);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign n_y = pipe[L-1];

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic void model_pass(input int x1, input int x2);
    for (int i = 0; i < N; i++)
      exp_y[i] = neuron_f(x1, x2, wm1[i], wm2[i], wmb[i]);
    exp_max = 0;
    for (int i = 1; i < N; i++)
      if (exp_y[i] > exp_y[exp_max]) exp_max = i;
  endfunction

  task automatic check(input string tag,
                       input logic signed [31:0] got,
                       input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int w1,
                           input int w2, input int b);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_w1 = 8'(w1);
    cfg_w2 = 8'(w2);
    cfg_b = 8'(b);
    wm1[a] = w1;
    wm2[a] = w2;
    wmb[a] = b;
    tick();
    cfg_we = 1'b0;
    check("cfg_err_idle", cfg_err, 0);
  endtask

  task automatic run_pass(input int x1, input int x2,
                          input int stall_j, input int stall_n,
                          input bit err_en, input bit hold,
                          input bit acc_cfg);
    int c;
    int a;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_x1 = 8'(x1);
    in_x2 = 8'(x2);
    if (acc_cfg) begin
      a = int'($urandom_range(0, N - 1));
      cfg_we = 1'b1;
      cfg_addr = AW'(a);
      wm1[a] = rnd8();
      wm2[a] = rnd8();
      wmb[a] = rnd8();
      cfg_w1 = 8'(wm1[a]);
      cfg_w2 = 8'(wm2[a]);
      cfg_b = 8'(wmb[a]);
    end
    model_pass(x1, x2);
    tick();
    cfg_we = 1'b0;
    if (!hold) in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    c = 0;
    while (c < 100 && !out_valid) begin
      check("n_x1", n_x1, c < N ? x1 : 0);
      check("n_x2", n_x2, c < N ? x2 : 0);
      check("n_w1", n_w1, c < N ? wm1[c] : 0);
      check("n_w2", n_w2, c < N ? wm2[c] : 0);
      check("n_b", n_b, c < N ? wmb[c] : 0);
      check("cfg_err_busy", cfg_err, (err_en && c == 2) ? 1 : 0);
      if (err_en && c == 1) begin
        cfg_we = 1'b1;
        cfg_addr = AW'($urandom_range(0, N - 1));
        cfg_w1 = 8'(rnd8());
        cfg_w2 = 8'(rnd8());
        cfg_b = 8'(rnd8());
      end else begin
        cfg_we = 1'b0;
      end
      if (hold) begin
        in_x1 = 8'(rnd8());
        in_x2 = 8'(rnd8());
      end
      tick();
      c++;
    end
    cfg_we = 1'b0;
    check("first_valid_cycle", c, N + L);
    for (int jj = 0; jj < N; jj++) begin
      if (jj == stall_j) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          check("stall_valid", out_valid, 1);
          check("stall_idx", out_idx, jj);
          check("stall_y", out_y, exp_y[jj]);
          tick();
        end
        out_ready = 1'b1;
      end
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, jj);
      check("out_y", out_y, exp_y[jj]);
      check("out_last", out_last, (jj == N - 1) ? 1 : 0);
      check("out_max_idx", out_max_idx, exp_max);
      tick();
    end
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
  endtask

  task automatic run_abort(input int x1, input int x2);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_x1 = 8'(x1);
    in_x2 = 8'(x2);
    tick();
    in_valid = 1'b0;
    repeat (N + 1) tick();
    check("abort_busy", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_y", out_y, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      wm1[i] = 0;
      wm2[i] = 0;
      wmb[i] = 0;
    end
    repeat (12) begin
      check("abort_no_out", out_valid, 0);
      tick();
    end
    check("abort_cfg_err", cfg_err, 0);
  endtask

  initial begin
    bit prev_hold;
    bit hold;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_w1 = '0;
    cfg_w2 = '0;
    cfg_b = '0;
    in_valid = 1'b0;
    in_x1 = '0;
    in_x2 = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      wm1[i] = 0;
      wm2[i] = 0;
      wmb[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_out_y", out_y, 0);
    check("rst_n_w1", n_w1, 0);
    check("rst_max_idx", out_max_idx, 0);
    rst = 1'b0;
    tick();

    cfg_write(0, 1, 1, 0);
    cfg_write(1, 2, 0, 1);
    cfg_write(2, -1, -1, 0);
    cfg_write(3, 0, 3, -2);
    run_pass(10, 20, -1, 0, 0, 0, 0);
    run_pass(10, 20, 1, 5, 0, 0, 0);
    run_pass(10, 20, -1, 0, 1, 0, 0);
    run_pass(10, 20, -1, 0, 0, 0, 0);

    cfg_write(0, 0, 0, 5);
    cfg_write(1, 0, 0, 5);
    cfg_write(2, 0, 0, 2);
    cfg_write(3, 0, 0, 0);
    run_pass(7, -3, -1, 0, 0, 0, 0);

    run_pass(rnd8(), rnd8(), -1, 0, 0, 1, 0);
    run_pass(rnd8(), rnd8(), -1, 0, 0, 1, 1);
    run_pass(rnd8(), rnd8(), -1, 0, 0, 0, 0);

    prev_hold = 1'b0;
    for (int it = 0; it < 20; it++) begin
      if (!prev_hold && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3))
          cfg_write(int'($urandom_range(0, N - 1)),
                    rnd8(), rnd8(), rnd8());
      end
      hold = ($urandom_range(0, 3) == 0);
      run_pass(rnd8(), rnd8(),
               ($urandom_range(0, 2) == 0) ?
                 int'($urandom_range(0, N - 1)) : -1,
               int'($urandom_range(1, 4)),
               $urandom_range(0, 3) == 0,
               hold,
               $urandom_range(0, 2) == 0);
      prev_hold = hold;
    end
    in_valid = 1'b0;

    run_abort(10, 20);
    run_pass(33, -44, -1, 0, 0, 0, 0);
    cfg_write(2, 5, 5, 5);
    run_pass(rnd8(), rnd8(), 3, 2, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
